// File: rtl/hv_core_v2.sv
// hv_core_v2: one hyperdimensional lane core -- 16-bit instruction stream, block-RAM item memory, register file.
// Optional HV_CORE_BUNDLE_EN adds per-bit saturating bundling counters; without it SIGN loads the external sign_bit.
module hv_core_v2 #(
  parameter int DIM    = 1023,
  parameter int ADDR_W = 9,
  parameter int NREG   = 4,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gen,
  input  logic              update_item,
  input  logic [ADDR_W-1:0] item_a,
  input  logic [DIM:0]      rand_num,
  input  logic              get_v,
  input  logic [15:0]       get_d,
  input  logic [DIM:0]      sign_bit,
  output logic              store,
  output logic [DIM:0]      core_result,
  output logic              last,
  output logic              gen_conflict
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_WB    = 4'd2;
  localparam logic [3:0] OP_ROR   = 4'd3;
  localparam logic [3:0] OP_ROL   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_MOVE  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_ACC   = 4'd8;
  localparam logic [3:0] OP_SIGN  = 4'd9;
  localparam logic [3:0] OP_LAST  = 4'd10;

  // Accept-stage decode
  logic [3:0]        op_in;
  logic [1:0]        rd_in;
  logic [1:0]        rs_in;
  logic [ADDR_W-1:0] addr_in;

  assign op_in   = get_d[15:12];
  assign rd_in   = 2'(32'(get_d[11:10]) % NREG);
  assign rs_in   = 2'(32'(get_d[1:0]) % NREG);
  assign addr_in = get_d[ADDR_W-1:0];

  logic unused_inst;
  assign unused_inst = ^get_d;

  // Execute-stage instruction registers
  logic [3:0]        op_reg;
  logic [1:0]        rd_reg;
  logic [1:0]        rs_reg;
  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= OP_NOP;
      rd_reg   <= '0;
      rs_reg   <= '0;
      addr_reg <= '0;
    end else if (get_v) begin
      op_reg   <= op_in;
      rd_reg   <= rd_in;
      rs_reg   <= rs_in;
      addr_reg <= addr_in;
    end else begin
      op_reg   <= OP_NOP;
    end
  end

  // Register file
  logic [DIM:0] regs [NREG];
  logic [DIM:0] ex_rd_val;
  logic [DIM:0] ex_rs_val;

  assign ex_rd_val = regs[rd_reg];
  assign ex_rs_val = regs[rs_reg];

  logic ex_sign;
  logic ex_acc;
  logic wb_en;
  logic rand_req;
  logic rand_en;

  assign ex_sign  = (op_reg == OP_SIGN);
  assign ex_acc   = (op_reg == OP_ACC);
  assign wb_en    = (op_reg == OP_WB) && !rst;
  assign rand_req = gen && update_item;
  assign rand_en  = rand_req && !wb_en;

  // Item memory: one write port (WB beats random write), registered read-first read
  logic [DIM:0] mem [2**ADDR_W];
  logic [DIM:0] mem_q;

  always_ff @(posedge clk) begin
    if (wb_en) begin
      mem[addr_reg] <= ex_rd_val;
    end else if (rand_en) begin
      mem[item_a] <= rand_num;
    end
    mem_q <= mem[addr_in];
  end

  // A LOAD accepted while a WB to the same address executes takes the WB data instead of the stale read
  logic         fwd_hit_reg;
  logic [DIM:0] fwd_data_reg;
  logic [DIM:0] load_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      fwd_hit_reg  <= wb_en && get_v && (op_in == OP_LOAD) && (addr_in == addr_reg);
      fwd_data_reg <= ex_rd_val;
    end
  end

  assign load_data = fwd_hit_reg ? fwd_data_reg : mem_q;

  // Majority vector source for SIGN
  logic [DIM:0] sign_vec;

`ifdef HV_CORE_BUNDLE_EN
  localparam logic signed [CNT_W-1:0] CNT_MAX  = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic signed [CNT_W-1:0] CNT_MIN  = -CNT_MAX;
  localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;

  logic unused_sign_bit;
  assign unused_sign_bit = ^sign_bit;

  genvar gi;
  generate
    for (gi = 0; gi <= DIM; gi++) begin : g_cnt
      logic signed [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst || ex_sign) begin
          cnt_reg <= '0;
        end else if (ex_acc) begin
          if (ex_rd_val[gi]) begin
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
          end else begin
            if (cnt_reg != CNT_MIN) cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
      end

      // A zero count is a tie: break it with the random vector
      assign sign_vec[gi] = (cnt_reg > CNT_ZERO) ? 1'b1 :
                            (cnt_reg < CNT_ZERO) ? 1'b0 : rand_num[gi];
    end
  endgenerate
`else
  logic unused_acc;
  assign unused_acc = ex_acc;
  assign sign_vec   = sign_bit;
`endif

  // Execute stage: register writes and registered outputs
  logic         store_reg;
  logic         last_reg;
  logic         conflict_reg;
  logic [DIM:0] result_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      store_reg    <= 1'b0;
      last_reg     <= 1'b0;
      conflict_reg <= 1'b0;
      result_reg   <= '0;
    end else begin
      store_reg    <= (op_reg == OP_STORE);
      last_reg     <= (op_reg == OP_LAST);
      conflict_reg <= rand_req && wb_en;
      result_reg   <= (op_reg == OP_STORE) ? ex_rd_val : '0;
      case (op_reg)
        OP_LOAD: regs[rd_reg] <= load_data;
        OP_ROR:  regs[rd_reg] <= {ex_rd_val[0], ex_rd_val[DIM:1]};
        OP_ROL:  regs[rd_reg] <= {ex_rd_val[DIM-1:0], ex_rd_val[DIM]};
        OP_XOR:  regs[rd_reg] <= ex_rd_val ^ ex_rs_val;
        OP_MOVE: regs[rd_reg] <= ex_rs_val;
        OP_SIGN: regs[rd_reg] <= sign_vec;
        default: ;
      endcase
    end
  end

  assign store        = store_reg;
  assign last         = last_reg;
  assign gen_conflict = conflict_reg;
  assign core_result  = result_reg;

endmodule

// File: tb/tb_hv_core_v2.sv
// Directed self-checking bench for hv_core_v2 (DIM=15, ADDR_W=4, NREG=4, CNT_W=3).
// Exercises the bundling counters when HV_CORE_BUNDLE_EN is defined, the external sign_bit path otherwise.
module tb_hv_core_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        gen;
  logic        update_item;
  logic [3:0]  item_a;
  logic [15:0] rand_num;
  logic        get_v;
  logic [15:0] get_d;
  logic [15:0] sign_bit;
  logic        store;
  logic [15:0] core_result;
  logic        last;
  logic        gen_conflict;

  int n_cmp = 0;
  int n_err = 0;

  hv_core_v2 #(.DIM(15), .ADDR_W(4), .NREG(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .gen(gen), .update_item(update_item), .item_a(item_a),
    .rand_num(rand_num), .get_v(get_v), .get_d(get_d), .sign_bit(sign_bit),
    .store(store), .core_result(core_result), .last(last), .gen_conflict(gen_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] w);
    get_v = 1'b1;
    get_d = w;
    tick();
    get_v = 1'b0;
    get_d = 16'h0000;
  endtask

  task automatic rwrite(input logic [3:0] a, input logic [15:0] v);
    gen = 1'b1; update_item = 1'b1; item_a = a; rand_num = v;
    tick();
    gen = 1'b0; update_item = 1'b0;
  endtask

  // STORE rd, then check the pulse and the value two edges after acceptance, then its end
  task automatic do_store(input logic [1:0] rd, input logic [15:0] exp, input string tag);
    issue({4'h7, rd, 10'h000});
    tick();
    check({tag, "_store"}, {15'h0, store}, 16'h0001);
    check({tag, "_data"}, core_result, exp);
    tick();
    check({tag, "_pulse_end"}, {15'h0, store}, 16'h0000);
    check({tag, "_data_clr"}, core_result, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; gen = 1'b0; update_item = 1'b0; item_a = 4'h0; rand_num = 16'h0000;
    get_v = 1'b0; get_d = 16'h0000; sign_bit = 16'h0000;
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_store", {15'h0, store}, 16'h0000);
    check("rst_last", {15'h0, last}, 16'h0000);
    check("rst_conflict", {15'h0, gen_conflict}, 16'h0000);
    check("rst_result", core_result, 16'h0000);

    // Random write then LOAD/STORE
    rwrite(4'd3, 16'h00F0);
    issue(16'h1003);
    do_store(2'd0, 16'h00F0, "t1_load");

    // Rotations
    rwrite(4'd1, 16'h8001);
    issue(16'h1001);
    issue(16'h3000);
    do_store(2'd0, 16'hC000, "t2_ror");
    issue(16'h4000);
    issue(16'h4000);
    do_store(2'd0, 16'h0003, "t2_rol");

    // WB forwarding and write-port conflict
    rwrite(4'd2, 16'hA5C3);
    issue(16'h1402);
    issue(16'h2405);
    gen = 1'b1; update_item = 1'b1; item_a = 4'd5; rand_num = 16'h1111;
    issue(16'h1805);
    gen = 1'b0; update_item = 1'b0;
    check("t3_conflict", {15'h0, gen_conflict}, 16'h0001);
    tick();
    check("t3_conflict_end", {15'h0, gen_conflict}, 16'h0000);
    do_store(2'd2, 16'hA5C3, "t3_fwd");
    issue(16'h1C05);
    do_store(2'd3, 16'hA5C3, "t3_mem");

    // Read-first on same-cycle random write
    rwrite(4'd6, 16'h1357);
    gen = 1'b1; update_item = 1'b1; item_a = 4'd6; rand_num = 16'h2468;
    issue(16'h1006);
    gen = 1'b0; update_item = 1'b0;
    do_store(2'd0, 16'h1357, "t_rdfirst_old");
    issue(16'h1006);
    do_store(2'd0, 16'h2468, "t_rdfirst_new");

    // MOVE r1<=r0 then XOR r1^=r2
    issue(16'h6400);
    issue(16'h5402);
    do_store(2'd1, 16'h81AB, "t_xor");

    // LAST pulse and an undefined opcode
    issue(16'hA000);
    tick();
    check("last_pulse", {15'h0, last}, 16'h0001);
    check("last_nostore", {15'h0, store}, 16'h0000);
    tick();
    check("last_end", {15'h0, last}, 16'h0000);
    issue(16'hB000);
    tick();
    check("op11_store", {15'h0, store}, 16'h0000);
    check("op11_last", {15'h0, last}, 16'h0000);

`ifdef HV_CORE_BUNDLE_EN
    rwrite(4'd7, 16'hFFFF);
    rwrite(4'd8, 16'h0000);
    rwrite(4'd9, 16'h00FF);
    issue(16'h1007);
    issue(16'h1408);
    issue(16'h1809);
    rand_num = 16'h5A5A;
    repeat (5) issue(16'h8000);
    issue(16'h9C00);
    do_store(2'd3, 16'hFFFF, "t4_all_ones");
    repeat (5) issue(16'h8000);
    repeat (3) issue(16'h8400);
    issue(16'h9C00);
    do_store(2'd3, 16'h5A5A, "t4_sat_pos_tie");
    repeat (5) issue(16'h8000);
    repeat (4) issue(16'h8400);
    issue(16'h9C00);
    do_store(2'd3, 16'h0000, "t4_sat_pos_neg");
    rand_num = 16'hC3C3;
    repeat (5) issue(16'h8400);
    repeat (3) issue(16'h8000);
    issue(16'h9C00);
    do_store(2'd3, 16'hC3C3, "t4_sat_neg_tie");
    issue(16'h8800);
    issue(16'h9C00);
    do_store(2'd3, 16'h00FF, "t4_mixed");
    issue(16'h8000);
    issue(16'h8400);
    issue(16'h9C00);
    do_store(2'd3, 16'hC3C3, "t4_tie");
`else
    sign_bit = 16'h1234;
    issue(16'h9400);
    do_store(2'd1, 16'h1234, "t5_sign");
    issue(16'h8400);
    do_store(2'd1, 16'h1234, "t5_acc_nop");
    sign_bit = 16'hBEEF;
    issue(16'h9800);
    do_store(2'd2, 16'hBEEF, "t5_sign2");
`endif

    // Reset discards in-flight STORE, LAST and WB
    issue(16'h7400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_store", {15'h0, store}, 16'h0000);
    check("t6_result", core_result, 16'h0000);
    check("t6_last", {15'h0, last}, 16'h0000);
    check("t6_conflict", {15'h0, gen_conflict}, 16'h0000);
    tick();
    check("t6_store_late", {15'h0, store}, 16'h0000);
    issue(16'hA000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_last_disc", {15'h0, last}, 16'h0000);
    tick();
    check("t6_last_late", {15'h0, last}, 16'h0000);
    rwrite(4'd10, 16'h0F0F);
    issue(16'h280A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(16'h100A);
    do_store(2'd0, 16'h0F0F, "t6_wb_disc");
    do_store(2'd3, 16'h0000, "t6_reg_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
